// File: rtl/modn_counter_pkg.sv
// Shared constants for the programmable mod-M counter: request priority codes
// and the smallest modulus the counter accepts.
package modn_counter_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_HOLD  = 2'd0;
  localparam logic [OP_W-1:0] OP_MOD   = 2'd1;
  localparam logic [OP_W-1:0] OP_LOAD  = 2'd2;
  localparam logic [OP_W-1:0] OP_COUNT = 2'd3;

  localparam int unsigned MIN_MODULUS = 2;

endpackage

// File: rtl/modn_step_unit.sv
// Combinational next-count calculator: advances count by s (already clamped
// to m-1) up or down, wrapping modulo m or saturating at the bounds.
module modn_step_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] s,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] next,
  output logic             wrap
);

  localparam int unsigned EXT_W = WIDTH + 1;

  logic [EXT_W-1:0] sum;
  logic [EXT_W-1:0] borrow_sum;

  // One spare bit keeps count+s and count+m-s exact before reduction.
  assign sum        = {1'b0, count} + {1'b0, s};
  assign borrow_sum = {1'b0, count} + {1'b0, m} - {1'b0, s};

  always_comb begin
    next = count;
    wrap = 1'b0;
    if (up) begin
      if (sum < {1'b0, m}) begin
        next = WIDTH'(sum);
      end else if (sat) begin
        next = m - WIDTH'(1);
      end else begin
        next = WIDTH'(sum - {1'b0, m});
        wrap = 1'b1;
      end
    end else begin
      if (count >= s) begin
        next = count - s;
      end else if (sat) begin
        next = '0;
      end else begin
        next = WIDTH'(borrow_sum);
        wrap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modn_counter_gen.sv
// Run-time programmable mod-M up/down counter with enable, variable step,
// synchronous load, wrap-or-saturate mode and terminal/wrap status.
module modn_counter_gen
  import modn_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_DEFAULT = 11,
  parameter int unsigned STEP_W    = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              En,
  input  logic              UpOrDown,
  input  logic              Sat,
  input  logic [STEP_W-1:0] Step,
  input  logic              Load,
  input  logic [WIDTH-1:0]  LoadVal,
  input  logic              ModSet,
  input  logic [WIDTH-1:0]  ModVal,
  output logic [WIDTH-1:0]  Count,
  output logic [WIDTH-1:0]  Modulus,
  output logic              Wrap,
  output logic              AtMax,
  output logic              AtMin,
  output logic              ModErr
);

  localparam int unsigned CMP_W = (WIDTH > STEP_W) ? WIDTH : STEP_W;

  if (N_DEFAULT < MIN_MODULUS || N_DEFAULT > (2 ** WIDTH) - 1) begin : g_bad_default
    $error("modn_counter_gen: N_DEFAULT out of range 2 .. 2**WIDTH-1");
  end

  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] max_count;
  logic [CMP_W-1:0] step_ext;
  logic [CMP_W-1:0] max_ext;
  logic [WIDTH-1:0] eff_step;
  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic             mod_ok;

  assign max_count = Modulus - WIDTH'(1);
  assign step_ext  = CMP_W'(Step);
  assign max_ext   = CMP_W'(max_count);
  assign eff_step  = (step_ext < max_ext) ? WIDTH'(step_ext) : max_count;
  assign mod_ok    = (ModVal >= WIDTH'(MIN_MODULUS));

  // Only the highest-priority request of the cycle is acted on.
  always_comb begin
    op = OP_HOLD;
    if (ModSet) begin
      op = OP_MOD;
    end else if (Load) begin
      op = OP_LOAD;
    end else if (En) begin
      op = OP_COUNT;
    end
  end

  modn_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .count (Count),
    .m     (Modulus),
    .s     (eff_step),
    .up    (UpOrDown),
    .sat   (Sat),
    .next  (step_next),
    .wrap  (step_wrap)
  );

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      Count   <= '0;
      Modulus <= WIDTH'(N_DEFAULT);
      Wrap    <= 1'b0;
      ModErr  <= 1'b0;
    end else begin
      Wrap   <= 1'b0;
      ModErr <= 1'b0;
      case (op)
        OP_MOD: begin
          if (mod_ok) begin
            Modulus <= ModVal;
            Count   <= '0;
          end else begin
            ModErr <= 1'b1;
          end
        end
        OP_LOAD: begin
          Count <= (LoadVal >= Modulus) ? max_count : LoadVal;
        end
        OP_COUNT: begin
          Count <= step_next;
          Wrap  <= step_wrap;
        end
        default: ;
      endcase
    end
  end

  assign AtMax = (Count == max_count);
  assign AtMin = (Count == '0);

endmodule
